// File: rtl/cpu_control_r_type.sv
// cpu_control_r_type: single-cycle MIPS-subset core (PC, IM, BR, ALU, DM).
// Optional macro CPU_BEQ_EN builds beq (comparator + branch adder).

package cpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_imm;
    logic       zext;
    logic       reg_we;
    logic       dst_rd;
    logic       mem_we;
    logic       mem_rd;
`ifdef CPU_BEQ_EN
    logic       branch;
`endif
  } ctrl_t;

endpackage

module cpu_regbank (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] registerBank [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0
                             : registerBank[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0
                             : registerBank[ra2];

  // Write port; $0 and reset cycles never commit
  always_ff @(posedge clk) begin
    if (rst_n && we && (wa != 5'd0))
      registerBank[wa] <= wd;
  end

endmodule

module cpu_imem (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  wa,
  input  logic [7:0]  wd,
  input  logic [7:0]  addr,
  output logic [31:0] instr
);

  logic [7:0] instBank [0:255];
  logic [7:0] a1;
  logic [7:0] a2;
  logic [7:0] a3;

  assign a1 = addr + 8'd1;
  assign a2 = addr + 8'd2;
  assign a3 = addr + 8'd3;

  assign instr = {instBank[addr],
                  instBank[a1],
                  instBank[a2],
                  instBank[a3]};

  // Byte load port for program images
  always_ff @(posedge clk) begin
    if (we)
      instBank[wa] <= wd;
  end

endmodule

module cpu_dmem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [5:0]  idx,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  logic [31:0] dataMemory [0:63];

  assign rd = dataMemory[idx];

  // Word store, held off while in reset
  always_ff @(posedge clk) begin
    if (rst_n && we)
      dataMemory[idx] <= wd;
  end

endmodule

module cpu_alu
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Operation select
  always_comb begin
    y = a + b;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = ($signed(a) < $signed(b))
                   ? 32'd1 : 32'd0;
      default: y = a + b;
    endcase
  end

endmodule

module cpu_decode
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  logic is_r;
  logic is_addi;
  logic is_slti;
  logic is_andi;
  logic is_ori;
  logic is_lw;
  logic is_sw;

  assign is_r    = (op == OP_R);
  assign is_addi = (op == OP_ADDI);
  assign is_slti = (op == OP_SLTI);
  assign is_andi = (op == OP_ANDI);
  assign is_ori  = (op == OP_ORI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);

`ifdef CPU_BEQ_EN
  logic is_beq;
  assign is_beq = (op == OP_BEQ);
`endif

  // Default is a NOP that still shows rs+signext(imm)
  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.src_imm = 1'b1;
    unique case (1'b1)
      is_r: begin
        ctrl.src_imm = 1'b0;
        ctrl.reg_we  = 1'b1;
        ctrl.dst_rd  = 1'b1;
        unique case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_NOR: ctrl.alu_op = ALU_NOR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl.src_imm = 1'b1;
            ctrl.reg_we  = 1'b0;
            ctrl.dst_rd  = 1'b0;
          end
        endcase
      end
      is_addi: begin
        ctrl.reg_we = 1'b1;
      end
      is_slti: begin
        ctrl.alu_op = ALU_SLT;
        ctrl.reg_we = 1'b1;
      end
      is_andi: begin
        ctrl.alu_op = ALU_AND;
        ctrl.zext   = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      is_ori: begin
        ctrl.alu_op = ALU_OR;
        ctrl.zext   = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      is_lw: begin
        ctrl.reg_we = 1'b1;
        ctrl.mem_rd = 1'b1;
      end
      is_sw: begin
        ctrl.mem_we = 1'b1;
      end
`ifdef CPU_BEQ_EN
      is_beq: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.src_imm = 1'b0;
        ctrl.branch  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

module cpu_control_r_type
  import cpu_pkg::*;
(
  input  logic        clk_CPU,
  input  logic        rst_CPU_n,
  output logic [31:0] resultado
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  ctrl_t       ctrl;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] ld_data;
  logic [31:0] wb;
  logic [4:0]  wa;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  cpu_imem IM (
    .clk   (clk_CPU),
    .we    (1'b0),
    .wa    (8'd0),
    .wd    (8'd0),
    .addr  (pc[7:0]),
    .instr (instr)
  );

  cpu_decode u_dec (
    .op    (op),
    .funct (funct),
    .ctrl  (ctrl)
  );

  assign wa = ctrl.dst_rd ? rd : rt;

  cpu_regbank BR (
    .clk   (clk_CPU),
    .rst_n (rst_CPU_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (ctrl.reg_we),
    .wa    (wa),
    .wd    (wb)
  );

  assign imm_ext = ctrl.zext
                 ? {16'd0, imm}
                 : {{16{imm[15]}}, imm};
  assign alu_b   = ctrl.src_imm ? imm_ext : rt_val;

  cpu_alu u_alu (
    .op (ctrl.alu_op),
    .a  (rs_val),
    .b  (alu_b),
    .y  (alu_y)
  );

  cpu_dmem DM (
    .clk   (clk_CPU),
    .rst_n (rst_CPU_n),
    .we    (ctrl.mem_we),
    .idx   (alu_y[7:2]),
    .wd    (rt_val),
    .rd    (ld_data)
  );

  assign wb        = ctrl.mem_rd ? ld_data : alu_y;
  assign resultado = rst_CPU_n ? wb : 32'd0;
  assign pc_plus4  = pc + 32'd4;

`ifdef CPU_BEQ_EN
  logic [31:0] br_off;
  logic        br_take;
  assign br_off  = {{14{imm[15]}}, imm, 2'b00};
  assign br_take = ctrl.branch && (rs_val == rt_val);
  assign pc_next = br_take ? (pc_plus4 + br_off)
                           : pc_plus4;
`else
  assign pc_next = pc_plus4;
`endif

  // Program counter, cleared at once by reset
  always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
    if (!rst_CPU_n)
      pc <= 32'd0;
    else
      pc <= pc_next;
  end

endmodule

// File: tb/tb_cpu_control_r_type.sv
// tb_cpu_control_r_type: directed and random programs
// checked against an instruction-level model of the core.

module tb_cpu_control_r_type;

  logic        clk_CPU   = 1'b0;
  logic        rst_CPU_n = 1'b0;
  logic [31:0] resultado;

  int tests = 0;
  int fails = 0;

  cpu_control_r_type dut (
    .clk_CPU   (clk_CPU),
    .rst_CPU_n (rst_CPU_n),
    .resultado (resultado)
  );

  always #5 clk_CPU = ~clk_CPU;

  logic [31:0] m_r  [32];
  logic [31:0] m_dm [64];
  logic [7:0]  m_im [256];
  logic [31:0] m_pc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rty(
    input logic [5:0] fn, input logic [4:0] d,
    input logic [4:0] s, input logic [4:0] t);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ity(
    input logic [5:0] op, input logic [4:0] t,
    input logic [4:0] s, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic set_reg(input int i, input logic [31:0] v);
    m_r[i] = v;
    dut.BR.registerBank[i] = v;
  endtask

  task automatic set_dm(input int i, input logic [31:0] v);
    m_dm[i] = v;
    dut.DM.dataMemory[i] = v;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      m_im[(a + k) % 256] = w[31 - 8*k -: 8];
      dut.IM.instBank[(a + k) % 256] = w[31 - 8*k -: 8];
    end
  endtask

  task automatic fill_im(input logic [31:0] w);
    for (int a = 0; a < 256; a += 4)
      put_word(a, w);
  endtask

  function automatic logic [31:0] rreg(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : m_r[i];
  endfunction

  // Execute one instruction on the model and return its write-back value
  task automatic m_step(output logic [31:0] res);
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] ins, x, y, se, ze, addr, npc;
    logic [4:0]  dst;
    logic        wr;
    a0 = m_pc[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    ins  = {m_im[a0], m_im[a1], m_im[a2], m_im[a3]};
    se   = {{16{ins[15]}}, ins[15:0]};
    ze   = {16'd0, ins[15:0]};
    x    = rreg(ins[25:21]);
    y    = rreg(ins[20:16]);
    addr = x + se;
    res  = addr;
    npc  = m_pc + 32'd4;
    wr   = 1'b0;
    dst  = ins[20:16];
    case (ins[31:26])
      6'h00: begin
        wr  = 1'b1;
        dst = ins[15:11];
        case (ins[5:0])
          6'h20: res = x + y;
          6'h22: res = x - y;
          6'h24: res = x & y;
          6'h25: res = x | y;
          6'h27: res = ~(x | y);
          6'h2a: res = ($signed(x) < $signed(y)) ? 1 : 0;
          default: wr = 1'b0;
        endcase
      end
      6'h08: begin wr = 1'b1; res = x + se; end
      6'h0a: begin
        wr  = 1'b1;
        res = ($signed(x) < $signed(se)) ? 1 : 0;
      end
      6'h0c: begin wr = 1'b1; res = x & ze; end
      6'h0d: begin wr = 1'b1; res = x | ze; end
      6'h23: begin wr = 1'b1; res = m_dm[addr[7:2]]; end
      6'h2b: m_dm[addr[7:2]] = y;
`ifdef CPU_BEQ_EN
      6'h04: begin
        res = x - y;
        if (x == y) npc = m_pc + 32'd4 + (se << 2);
      end
`endif
      default: ;
    endcase
    if (wr && dst != 5'd0) m_r[dst] = res;
    m_pc = npc;
  endtask

  task automatic run(input int n, input string tag);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pc"}, dut.pc, m_pc);
      m_step(exp);
      chk({tag, "_res"}, resultado, exp);
      @(posedge clk_CPU);
      @(negedge clk_CPU);
    end
  endtask

  task automatic cmp_state(input string tag);
    for (int i = 0; i < 32; i++)
      chk({tag, "_reg"}, dut.BR.registerBank[i], m_r[i]);
    for (int i = 0; i < 64; i++)
      chk({tag, "_dm"}, dut.DM.dataMemory[i], m_dm[i]);
  endtask

  // Enter reset and give every storage element a known value
  task automatic begin_test();
    @(negedge clk_CPU);
    rst_CPU_n = 1'b0;
    #1;
    chk("inrst_pc", dut.pc, 32'd0);
    chk("inrst_res", resultado, 32'd0);
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) set_reg(i, $urandom);
    for (int i = 0; i < 64; i++) set_dm(i, $urandom);
    fill_im(32'hFC00_0000);
  endtask

  task automatic go();
    @(negedge clk_CPU);
    rst_CPU_n = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  s, t, d;
    logic [15:0] im;
    logic [5:0]  fns [6];
    int k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
    s  = 5'($urandom_range(0, 7));
    t  = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    k  = $urandom_range(0, 9);
    case (k)
      0: return rty(fns[$urandom_range(0, 5)], d, s, t);
      1: return rty(6'($urandom), d, s, t);
      2: return ity(6'h08, t, s, im);
      3: return ity(6'h0a, t, s, im);
      4: return ity(6'h0c, t, s, im);
      5: return ity(6'h0d, t, s, im);
      6: return ity(6'h23, t, s, im);
      7: return ity(6'h2b, t, s, im);
      8: return ity(6'h04, t, s,
                    16'($urandom_range(0, 6)) - 16'd3);
      default: return {6'($urandom), 26'($urandom)};
    endcase
  endfunction

  initial begin
    // reset holds PC, suppresses writes, keeps registers
    begin_test();
    set_reg(1, 32'd5);
    put_word(0, ity(6'h08, 5'd1, 5'd0, 16'd9));
    repeat (2) @(posedge clk_CPU);
    #1;
    chk("rst_pc", dut.pc, 32'd0);
    chk("rst_res", resultado, 32'd0);
    chk("rst_r1", dut.BR.registerBank[1], 32'd5);
    go();
    run(1, "rst");
    chk("rst_r1_after", dut.BR.registerBank[1], 32'd9);

    // R-type
    begin_test();
    set_reg(1, 32'd7);
    set_reg(2, 32'd3);
    put_word(0,  rty(6'h20, 5'd3, 5'd1, 5'd2));
    put_word(4,  rty(6'h22, 5'd4, 5'd1, 5'd2));
    put_word(8,  rty(6'h24, 5'd5, 5'd1, 5'd2));
    put_word(12, rty(6'h25, 5'd6, 5'd1, 5'd2));
    put_word(16, rty(6'h27, 5'd7, 5'd1, 5'd2));
    put_word(20, rty(6'h2a, 5'd8, 5'd1, 5'd2));
    put_word(24, rty(6'h2a, 5'd9, 5'd2, 5'd1));
    go();
    run(7, "rtype");
    chk("add", dut.BR.registerBank[3], 32'd10);
    chk("sub", dut.BR.registerBank[4], 32'd4);
    chk("and", dut.BR.registerBank[5], 32'd3);
    chk("or",  dut.BR.registerBank[6], 32'd7);
    chk("nor", dut.BR.registerBank[7], 32'hFFFF_FFF8);
    chk("slt0", dut.BR.registerBank[8], 32'd0);
    chk("slt1", dut.BR.registerBank[9], 32'd1);

    // I-type and writes to $0
    begin_test();
    set_reg(0, 32'd0);
    put_word(0,  ity(6'h08, 5'd1, 5'd0, 16'hFFFF));
    put_word(4,  ity(6'h0d, 5'd2, 5'd0, 16'hFFFF));
    put_word(8,  ity(6'h0a, 5'd3, 5'd1, 16'd0));
    put_word(12, ity(6'h08, 5'd0, 5'd0, 16'd5));
    go();
    run(4, "itype");
    chk("addi", dut.BR.registerBank[1], 32'hFFFF_FFFF);
    chk("ori",  dut.BR.registerBank[2], 32'h0000_FFFF);
    chk("slti", dut.BR.registerBank[3], 32'd1);
    chk("r0",   dut.BR.registerBank[0], 32'd0);

    // loads and stores
    begin_test();
    set_dm(2, 32'h1234_5678);
    put_word(0, ity(6'h23, 5'd4, 5'd0, 16'd8));
    put_word(4, ity(6'h2b, 5'd4, 5'd0, 16'd12));
    put_word(8, ity(6'h23, 5'd5, 5'd0, 16'd9));
    go();
    chk("lw_res", resultado, 32'h1234_5678);
    run(3, "mem");
    chk("lw_r4", dut.BR.registerBank[4], 32'h1234_5678);
    chk("sw_dm3", dut.DM.dataMemory[3], 32'h1234_5678);
    chk("lw_r5", dut.BR.registerBank[5], 32'h1234_5678);
    cmp_state("mem");

    // beq equal and unequal
    for (int u = 0; u < 2; u++) begin
      begin_test();
      set_reg(1, 32'd4);
      set_reg(2, (u == 0) ? 32'd4 : 32'd5);
      put_word(0, ity(6'h04, 5'd2, 5'd1, 16'd2));
      go();
      run(1, "beq");
`ifdef CPU_BEQ_EN
      chk("beq_pc", dut.pc, (u == 0) ? 32'd12 : 32'd4);
`else
      chk("beq_pc", dut.pc, 32'd4);
`endif
      cmp_state("beq");
    end

    // unknown opcode
    begin_test();
    put_word(0, 32'hFC00_0000 | 32'($urandom_range(0, 32'h03FF_FFFF)));
    go();
    run(1, "unk");
    chk("unk_pc", dut.pc, 32'd4);
    cmp_state("unk");

    // wrap 252 -> 0
    begin_test();
    fill_im(ity(6'h08, 5'd1, 5'd1, 16'd1));
    put_word(0, ity(6'h0d, 5'd2, 5'd0, 16'h0055));
    go();
    run(64, "wrap");
    chk("wrap_pc", dut.pc, 32'h100);
    chk("wrap_res", resultado, 32'h55);
    run(2, "wrap2");
    cmp_state("wrap");

    // reset in the middle of a program
    begin_test();
    for (int a = 0; a < 256; a += 4) put_word(a, rnd_instr());
    go();
    run(10, "mid");
    #2;
    rst_CPU_n = 1'b0;
    #1;
    chk("mid_pc", dut.pc, 32'd0);
    chk("mid_res", resultado, 32'd0);
    @(posedge clk_CPU);
    @(negedge clk_CPU);
    cmp_state("midrst");
    m_pc = 32'd0;
    go();
    run(10, "mid2");
    cmp_state("mid2");

    // random programs
    for (int p = 0; p < 4; p++) begin
      begin_test();
      for (int a = 0; a < 256; a += 4) put_word(a, rnd_instr());
      go();
      run(80, "rnd");
      cmp_state("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
